// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, per-mode sizes,
// GF(2^8) doubling and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Forward S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return nk_of(kl) + 4'd6;
  endfunction

  // Total schedule words 4*(Nr+1).
  function automatic logic [5:0] words_of(input logic [1:0] kl);
    return {nr_of(kl), 2'b00} + 6'd4;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel byte S-box lookups.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // One lookup per byte lane
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_out[8*gi +: 8] = sbox(word_in[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_sched.sv
// Sequential AES key schedule: one schedule word per cycle through a shared
// SubWord unit, round keys assembled four words at a time into a small FIFO.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int KEY_MAX_BITS = 256,
  parameter int OUT_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [KEY_MAX_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    err,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last
);

  localparam int KEY_WORDS = KEY_MAX_BITS / 32;
  localparam int PTR_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1);
  localparam int ENT_W     = 133;  // {data[127:0], idx[3:0], last}

  state_e             state_q, state_d;
  logic [1:0]         klen_q, klen_d;
  logic [5:0]         wcnt_q, wcnt_d;
  logic [2:0]         phase_q, phase_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [31:0]        win_q [8];
  logic [31:0]        win_d [8];
  logic [31:0]        asm_q [3];
  logic [31:0]        asm_d [3];
  logic               err_q, err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   fifo_mem [OUT_DEPTH];

  logic [31:0]        key_w [8];
  logic [3:0]         nk_cur;
  logic [5:0]         wtot;
  logic [2:0]         top_idx;
  logic [31:0]        prev_w, sub_in, sub_out, new_word;
  logic               mode_ok, pop, push, full, advance;
  logic [ENT_W-1:0]   push_entry, head;

  // Split the left-aligned key into words; absent words read as zero
  for (genvar gi = 0; gi < 8; gi++) begin : g_key
    if (gi < KEY_WORDS) begin : g_used
      assign key_w[gi] = key_in[KEY_MAX_BITS-1-32*gi -: 32];
    end else begin : g_zero
      assign key_w[gi] = 32'h0;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The window holds w[i-Nk..i-1]; during the key phase it simply rotates,
  // so the key words come out of slot 0 and land back in order.
  assign nk_cur  = nk_of(klen_q);
  assign wtot    = words_of(klen_q);
  assign top_idx = 3'(nk_cur - 4'd1);
  assign prev_w  = win_q[top_idx];
  assign sub_in  = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_sbox_word u_sbox (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Next schedule word from the window, SubWord result and rcon
  always_comb begin
    new_word = win_q[0] ^ prev_w;
    if (wcnt_q < {2'b00, nk_cur}) begin
      new_word = win_q[0];
    end else if (phase_q == 3'd0) begin
      new_word = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
    end else if (nk_cur == 4'd8 && phase_q == 3'd4) begin
      new_word = win_q[0] ^ sub_out;
    end
  end

  assign mode_ok    = (key_len != KL_BAD) && (32 * int'(nk_of(key_len)) <= KEY_MAX_BITS);
  assign rk_valid   = (cnt_q != '0);
  assign pop        = rk_valid && rk_ready;
  assign full       = (cnt_q == CNT_W'(OUT_DEPTH));
  assign advance    = (state_q == ST_EXPAND) && (!full || pop);
  assign push       = advance && (wcnt_q[1:0] == 2'b11);
  assign push_entry = {asm_q[0], asm_q[1], asm_q[2], new_word, wcnt_q[5:2],
                       wcnt_q == wtot - 6'd1};
  assign head       = fifo_mem[rd_ptr_q];

  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;
  assign rk_data = rk_valid ? head[132:5] : 128'h0;
  assign rk_idx  = rk_valid ? head[4:1]   : 4'h0;
  assign rk_last = rk_valid && head[0];

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM next state plus schedule datapath update
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
    asm_d   = asm_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            klen_d  = key_len;
            wcnt_d  = 6'd0;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            for (int j = 0; j < 8; j++) win_d[j] = key_w[j];
            state_d = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        if (advance) begin
          case (wcnt_q[1:0])
            2'd0:    asm_d[0] = new_word;
            2'd1:    asm_d[1] = new_word;
            2'd2:    asm_d[2] = new_word;
            default: ;
          endcase
          for (int j = 0; j < 7; j++) win_d[j] = win_q[j+1];
          win_d[7]       = win_q[7];
          win_d[top_idx] = new_word;
          wcnt_d  = wcnt_q + 6'd1;
          phase_d = (phase_q == top_idx) ? 3'd0 : phase_q + 3'd1;
          if (phase_q == 3'd0 && wcnt_q >= {2'b00, nk_cur}) rcon_d = xtime(rcon_q);
          if (wcnt_q == wtot - 6'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      klen_q   <= 2'd0;
      wcnt_q   <= 6'd0;
      phase_q  <= 3'd0;
      rcon_q   <= 8'h01;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
      for (int j = 0; j < 3; j++) asm_q[j] <= 32'h0;
    end else begin
      state_q  <= state_d;
      klen_q   <= klen_d;
      wcnt_q   <= wcnt_d;
      phase_q  <= phase_d;
      rcon_q   <= rcon_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      asm_q    <= asm_d;
    end
  end

  // FIFO storage; validity is tracked by the occupancy counter
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors, random keys with
// random backpressure, rejected/ignored starts and mid-run reset.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, err, rk_valid, rk_last;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  always #5 clk = ~clk;

  aes_key_sched #(.KEY_MAX_BITS(256), .OUT_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  bit lat_chk = 1'b0;
  int rdy_mode = 0;
  logic [7:0]   sb [256];
  logic [132:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- reference model (from GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_rk(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4*r + 4; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {rk_data, rk_idx, rk_last}, 133'h0);
      end else begin
        chk("round_key", {rk_data, rk_idx, rk_last}, exp_q[0]);
        if (lat_chk) chk("latency", 133'(cyc - t_start), 133'(4*int'(rk_idx) + 5));
        if (rk_ready) begin
          $display("RK idx %0d data %h last %0d cycle %0d", rk_idx, rk_data, rk_last, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    int  hold = 0;
    bit  lvl = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        rk_ready = 1'b1;
      end else begin
        if (hold == 0) begin
          lvl  = ~lvl;
          hold = lvl ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 25));
        end
        hold--;
        rk_ready = lvl;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [1:0] kl, input logic [255:0] key, input bit ok);
    int nk, nr;
    @(posedge clk); #1;
    start = 1'b1; key_len = kl; key_in = key; t_start = cyc;
    if (ok) begin
      nk = 4 + 2*int'(kl);
      nr = nk + 6;
      for (int r = 0; r <= nr; r++)
        exp_q.push_back({model_rk(key, nk, r), 4'(r), r == nr});
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 133'(busy), 133'(ok));
    chk("err_after_start", 133'(err), 133'(!ok));
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("run_completes", 133'(n < 3000), 133'(1));
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("busy_low_after", 133'(busy), 133'(0));
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    build_sbox();
    // Pin the model with hand-known values
    chk("model_sbox_00", 133'(sb[0]), 133'(8'h63));
    chk("model_sbox_53", 133'(sb[8'h53]), 133'(8'hed));
    chk("model_128_r1", 133'(model_rk(K128, 4, 1)), 133'(128'ha0fafe1788542cb123a339392a6c7605));
    chk("model_128_r10", 133'(model_rk(K128, 4, 10)), 133'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("model_192_r12", 133'(model_rk(K192, 6, 12)), 133'(128'he98ba06f448c773c8ecc720401002202));
    chk("model_256_r14", 133'(model_rk(K256, 8, 14)), 133'(128'hfe4890d1e6188d0b046df344706c631e));

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rk_data, rk_idx, rk_last}, 133'h0);
    chk("reset_flags", 133'({busy, err, rk_valid}), 133'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Known-answer runs with no backpressure, latency checked per round
    rdy_mode = 0;
    lat_chk = 1'b1;
    do_start(2'd0, K128, 1'b1); wait_done();
    do_start(2'd1, K192, 1'b1); wait_done();
    do_start(2'd2, K256, 1'b1); wait_done();
    lat_chk = 1'b0;

    // Backpressure on the AES-128 vector, then random keys and modes
    rdy_mode = 1;
    do_start(2'd0, K128, 1'b1); wait_done();
    for (int n = 0; n < 6; n++) begin
      do_start(2'($urandom_range(0, 2)), rand_key(), 1'b1);
      wait_done();
    end
    rdy_mode = 0;

    // Invalid key length: one-cycle err, nothing else
    do_start(2'd3, rand_key(), 1'b0);
    @(negedge clk);
    chk("err_one_cycle", 133'(err), 133'(0));
    chk("no_valid_after_err", 133'({busy, rk_valid}), 133'(0));

    // Start while busy is ignored and the original sequence completes
    do_start(2'd0, rand_key(), 1'b1);
    repeat (8) @(posedge clk);
    #1 start = 1'b1; key_len = 2'd2; key_in = rand_key();
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("midrun_start_no_err", 133'({err, busy}), 133'(2'b01));
    wait_done();

    // Asynchronous reset during round 5, then a fresh key
    do_start(2'd0, rand_key(), 1'b1);
    begin
      int n = 0;
      while (!(rk_valid && rk_idx == 4'd5) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("reached_round5", 133'(n < 200), 133'(1));
    end
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {rk_data, rk_idx, rk_last}, 133'h0);
    chk("abort_flags", 133'({busy, err, rk_valid}), 133'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_chk = 1'b1;
    do_start(2'd1, rand_key(), 1'b1); wait_done();
    lat_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
